// File: rtl/spi_target.sv
// SPI mode-0 target with one-byte transmit/receive holding registers.
// All pin inputs are oversampled and edge-detected in the clk domain.
module spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCLK,
  input  logic       SD_CS,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_OE,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_empty,
  output logic [7:0] rx_data,
  output logic       rx_full,
  input  logic       rx_read,
  output logic       busy,
  output logic       overrun,
  output logic       underrun,
  input  logic       clr_err
);

  typedef enum logic {IDLE = 1'b0, SELECTED = 1'b1} state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sclk_prev_r;
  logic                   cs_prev_r;
  logic                   warm_r;
  logic                   armed_r;
  logic [2:0]             cnt_r;
  logic [7:0]             rx_shift_r;
  logic [7:0]             tx_shift_r;
  logic [7:0]             hold_r;
  logic [7:0]             rx_data_r;
  logic                   tx_empty_r;
  logic                   rx_full_r;
  logic                   miso_r;
  logic                   oe_r;
  logic                   busy_r;
  logic                   overrun_r;
  logic                   underrun_r;

  logic       sclk_s;
  logic       cs_s;
  logic       mosi_s;
  logic       sclk_rise_s;
  logic       sclk_fall_s;
  logic       cs_fall_s;
  logic       cs_rise_s;
  logic [7:0] next_byte_s;
  logic [7:0] rx_byte_s;

  // Byte handed to the shift register at a byte start: held data, or idle fill.
  function automatic logic [7:0] next_tx_byte(input logic empty, input logic [7:0] hold);
    if (empty) begin
      next_tx_byte = 8'hFF;
    end else begin
      next_tx_byte = hold;
    end
  endfunction

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_s & sclk_prev_r;
  // A select only counts once CS has been seen high since reset.
  assign cs_fall_s   = armed_r & cs_prev_r & ~cs_s;
  assign cs_rise_s   = cs_s & ~cs_prev_r;
  assign next_byte_s = next_tx_byte(tx_empty_r, hold_r);
  assign rx_byte_s   = {rx_shift_r[6:0], mosi_s};

  // Pin synchronizers, edge-history flops and the select arming flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= 1'b0;
      cs_prev_r   <= 1'b1;
      warm_r      <= 1'b0;
      armed_r     <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], SD_CS};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
      sclk_prev_r <= sclk_s;
      cs_prev_r   <= cs_s;
      warm_r      <= 1'b1;
      armed_r     <= armed_r | (warm_r & cs_sync_r[0]);
    end
  end

  // Transfer FSM, holding registers, handshakes and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      rx_shift_r <= 8'hFF;
      tx_shift_r <= 8'hFF;
      hold_r     <= 8'h00;
      rx_data_r  <= 8'h00;
      tx_empty_r <= 1'b1;
      rx_full_r  <= 1'b0;
      miso_r     <= 1'b1;
      oe_r       <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      // Strobes first; byte-start and error events below take priority.
      if (tx_load && tx_empty_r) begin
        hold_r     <= tx_data;
        tx_empty_r <= 1'b0;
      end
      if (rx_read) begin
        rx_full_r <= 1'b0;
      end
      if (clr_err) begin
        overrun_r  <= 1'b0;
        underrun_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          cnt_r  <= 3'd0;
          busy_r <= 1'b0;
          if (cs_fall_s) begin
            state_r    <= SELECTED;
            oe_r       <= 1'b1;
            tx_shift_r <= next_byte_s;
            miso_r     <= next_byte_s[7];
            if (tx_empty_r) begin
              underrun_r <= 1'b1;
            end else begin
              tx_empty_r <= 1'b1;
            end
          end else begin
            oe_r   <= 1'b0;
            miso_r <= 1'b1;
          end
        end
        SELECTED: begin
          if (cs_rise_s) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            busy_r  <= 1'b0;
            miso_r  <= 1'b1;
            oe_r    <= 1'b0;
          end else if (sclk_rise_s) begin
            rx_shift_r <= rx_byte_s;
            cnt_r      <= cnt_r + 3'd1;
            busy_r     <= (cnt_r != 3'd7);
            if (cnt_r == 3'd7) begin
              rx_data_r  <= rx_byte_s;
              rx_full_r  <= 1'b1;
              tx_shift_r <= next_byte_s;
              if (rx_full_r && !rx_read) begin
                overrun_r <= 1'b1;
              end
              if (tx_empty_r) begin
                underrun_r <= 1'b1;
              end else begin
                tx_empty_r <= 1'b1;
              end
            end
          end else if (sclk_fall_s) begin
            if (cnt_r != 3'd0) begin
              tx_shift_r <= {tx_shift_r[6:0], 1'b1};
              miso_r     <= tx_shift_r[6];
            end else begin
              miso_r <= tx_shift_r[7];
            end
          end else begin
            busy_r <= (cnt_r != 3'd0);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 3'd0;
          busy_r  <= 1'b0;
          miso_r  <= 1'b1;
          oe_r    <= 1'b0;
        end
      endcase
    end
  end

  assign MISO     = miso_r;
  assign MISO_OE  = oe_r;
  assign tx_empty = tx_empty_r;
  assign rx_data  = rx_data_r;
  assign rx_full  = rx_full_r;
  assign busy     = busy_r;
  assign overrun  = overrun_r;
  assign underrun = underrun_r;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a mode-0 controller model at clk/8 with
// hand-computed expectations for each scenario.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       SCLK = 1'b0;
  logic       SD_CS = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic       MISO_OE;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_empty;
  logic [7:0] rx_data;
  logic       rx_full;
  logic       rx_read = 1'b0;
  logic       busy;
  logic       overrun;
  logic       underrun;
  logic       clr_err = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0] got;
  logic [7:0] got2;

  spi_target #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SD_CS(SD_CS), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .tx_data(tx_data), .tx_load(tx_load),
    .tx_empty(tx_empty), .rx_data(rx_data), .rx_full(rx_full), .rx_read(rx_read),
    .busy(busy), .overrun(overrun), .underrun(underrun), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] d);
    @(negedge clk); tx_data = d; tx_load = 1'b1;
    @(negedge clk); tx_load = 1'b0;
  endtask

  task automatic do_read();
    @(negedge clk); rx_read = 1'b1;
    @(negedge clk); rx_read = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  task automatic select();
    @(negedge clk); SD_CS = 1'b0;
    wait_n(8);
  endtask

  task automatic deselect();
    @(negedge clk); SD_CS = 1'b1;
    wait_n(6);
  endtask

  // Shifts n bits MSB first; MISO captured just before each rise.
  // rd_last pulses rx_read on the clk edge that completes the byte.
  task automatic xfer_bits(input logic [7:0] m, input int n, input logic rd_last,
                           output logic [7:0] s);
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      MOSI = m[7-i];
      wait_n(4);
      s[7-i] = MISO;
      SCLK = 1'b1;
      if (rd_last && i == 7) begin
        wait_n(2); rx_read = 1'b1;
        wait_n(1); rx_read = 1'b0;
        wait_n(1);
      end else begin
        wait_n(4);
      end
      SCLK = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] m, output logic [7:0] s);
    xfer_bits(m, 8, 1'b0, s);
  endtask

  task automatic test_reset();
    wait_n(3);
    reset = 1'b0;
    wait_n(3);
    checks++; if ({MISO, MISO_OE, tx_empty, rx_full, busy, overrun, underrun} !== 7'b1010000) begin
      failures++; $display("FAIL reset_flags got=%b want=1010000", {MISO, MISO_OE, tx_empty, rx_full, busy, overrun, underrun});
    end
    checks++; if (rx_data !== 8'h00) begin
      failures++; $display("FAIL reset_rx_data got=%h want=00", rx_data);
    end
  endtask

  task automatic test_basic();
    do_load(8'hA5);
    checks++; if (tx_empty !== 1'b0) begin failures++; $display("FAIL basic_tx_empty_after_load got=%b want=0", tx_empty); end
    select();
    checks++; if (MISO_OE !== 1'b1) begin failures++; $display("FAIL basic_oe got=%b want=1", MISO_OE); end
    do_load(8'h00);
    xfer(8'h3C, got);
    checks++; if (got !== 8'hA5) begin failures++; $display("FAIL basic_miso got=%h want=a5", got); end
    checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL basic_rx_data got=%h want=3c", rx_data); end
    checks++; if ({rx_full, tx_empty, overrun, underrun} !== 4'b1100) begin
      failures++; $display("FAIL basic_flags got=%b want=1100", {rx_full, tx_empty, overrun, underrun});
    end
    deselect();
    do_read();
    checks++; if (rx_full !== 1'b0) begin failures++; $display("FAIL basic_rx_read got=%b want=0", rx_full); end
  endtask

  task automatic test_underrun();
    select();
    xfer(8'h00, got);
    checks++; if (got !== 8'hFF) begin failures++; $display("FAIL underrun_miso got=%h want=ff", got); end
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_flag got=%b want=1", underrun); end
    deselect();
    do_clr();
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_clr got=%b want=0", underrun); end
    do_read();
  endtask

  task automatic test_back_to_back();
    select();
    xfer(8'h11, got);
    xfer(8'h22, got);
    checks++; if (rx_data !== 8'h22) begin failures++; $display("FAIL overrun_rx_data got=%h want=22", rx_data); end
    checks++; if ({overrun, rx_full} !== 2'b11) begin failures++; $display("FAIL overrun_flags got=%b want=11", {overrun, rx_full}); end
    deselect();
    do_read();
    checks++; if ({overrun, rx_full} !== 2'b10) begin failures++; $display("FAIL overrun_read got=%b want=10", {overrun, rx_full}); end
    do_clr();
    checks++; if ({overrun, underrun} !== 2'b00) begin failures++; $display("FAIL overrun_clr got=%b want=00", {overrun, underrun}); end
  endtask

  task automatic test_abort();
    select();
    xfer_bits(8'hF0, 5, 1'b0, got);
    wait_n(1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_mid got=%b want=1", busy); end
    SD_CS = 1'b1;
    wait_n(3);
    checks++; if ({busy, MISO, MISO_OE, rx_full} !== 4'b0100) begin
      failures++; $display("FAIL abort_outputs got=%b want=0100", {busy, MISO, MISO_OE, rx_full});
    end
    checks++; if (rx_data !== 8'h22) begin failures++; $display("FAIL abort_rx_data got=%h want=22", rx_data); end
    wait_n(4);
    do_clr();
  endtask

  task automatic test_collisions();
    // rx_read on the completion edge keeps rx_full and suppresses overrun
    select();
    xfer(8'h55, got);
    xfer_bits(8'h66, 8, 1'b1, got);
    checks++; if ({rx_full, overrun} !== 2'b10) begin failures++; $display("FAIL rdcoll_flags got=%b want=10", {rx_full, overrun}); end
    checks++; if (rx_data !== 8'h66) begin failures++; $display("FAIL rdcoll_rx_data got=%h want=66", rx_data); end
    deselect();
    do_read();
    do_clr();
    // second load while full is ignored
    do_load(8'hA5);
    do_load(8'h5A);
    select();
    xfer(8'h00, got);
    checks++; if (got !== 8'hA5) begin failures++; $display("FAIL ldcoll_miso got=%h want=a5", got); end
    deselect();
    do_read();
    do_clr();
    // load on the select edge with empty holding: FF now, loaded byte next
    @(negedge clk); SD_CS = 1'b0;
    wait_n(2); tx_data = 8'hC3; tx_load = 1'b1;
    wait_n(1); tx_load = 1'b0;
    wait_n(5);
    checks++; if ({tx_empty, underrun} !== 2'b01) begin failures++; $display("FAIL startcoll_flags got=%b want=01", {tx_empty, underrun}); end
    xfer(8'h00, got);
    xfer(8'h00, got2);
    checks++; if ({got, got2} !== 16'hFFC3) begin failures++; $display("FAIL startcoll_miso got=%h want=ffc3", {got, got2}); end
    deselect();
    do_read();
    do_clr();
  endtask

  task automatic test_reset_mid();
    do_load(8'h81);
    select();
    xfer_bits(8'hE0, 3, 1'b0, got);
    @(negedge clk); reset = 1'b1;
    #1;
    checks++; if ({MISO, MISO_OE, tx_empty, rx_full, busy, overrun, underrun} !== 7'b1010000) begin
      failures++; $display("FAIL rstmid_flags got=%b want=1010000", {MISO, MISO_OE, tx_empty, rx_full, busy, overrun, underrun});
    end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rstmid_rx_data got=%h want=00", rx_data); end
    wait_n(3);
    reset = 1'b0;
    wait_n(10);
    checks++; if (MISO_OE !== 1'b0) begin failures++; $display("FAIL rstmid_no_reselect got=%b want=0", MISO_OE); end
    deselect();
    do_load(8'h96);
    select();
    xfer(8'h0F, got);
    checks++; if (got !== 8'h96) begin failures++; $display("FAIL rstmid_miso got=%h want=96", got); end
    checks++; if ({rx_data, rx_full} !== {8'h0F, 1'b1}) begin
      failures++; $display("FAIL rstmid_rx got=%h/%b want=0f/1", rx_data, rx_full);
    end
    deselect();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_collisions();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
